// File: rtl/decode_stage_if.sv
// Bus bundle for decode_stage: fetch-side instruction handshake, flush, and
// issue-side decoded fields with their own handshake.
interface decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    // A word moves across either handshake only on a rising edge where valid
    // and ready are both 1; a source holds valid and its data stable until
    // then, and ready may depend combinationally on the other side.
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [XLEN-1:0]  imm;
    logic             is_from_rf;
    logic [4:0]       alu_op;
    logic             rf_we;
    logic             illegal;
    logic [CNT_W-1:0] ill_cnt;

    modport master (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, rd, rs1, rs2, imm, is_from_rf, alu_op,
               rf_we, illegal, ill_cnt
    );

    modport slave (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, rd, rs1, rs2, imm, is_from_rf, alu_op,
               rf_we, illegal, ill_cnt
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready output register, flush and an
// illegal-instruction counter. Define DECODE_MULDIV_EN to decode the M extension.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 16
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [4:0] ALU_NONE = 5'h00;
    localparam logic [4:0] ALU_ADD  = 5'h01;
    localparam logic [4:0] ALU_XOR  = 5'h02;
    localparam logic [4:0] ALU_OR   = 5'h03;
    localparam logic [4:0] ALU_AND  = 5'h04;
    localparam logic [4:0] ALU_SUB  = 5'h05;
    localparam logic [4:0] ALU_SLTU = 5'h06;
    localparam logic [4:0] ALU_SLL  = 5'h07;
    localparam logic [4:0] ALU_SRL  = 5'h08;
    localparam logic [4:0] ALU_SRA  = 5'h09;
    localparam logic [4:0] ALU_SLT  = 5'h0A;

    localparam logic [5:0] REG_LIMIT = 6'(NREGS);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] f_rd;
    logic [4:0] f_rs1;
    logic [4:0] f_rs2;

    assign opcode = bus.instr[6:0];
    assign f_rd   = bus.instr[11:7];
    assign funct3 = bus.instr[14:12];
    assign f_rs1  = bus.instr[19:15];
    assign f_rs2  = bus.instr[24:20];
    assign funct7 = bus.instr[31:25];

    logic            dec_ok;
    logic            dec_lui;
    logic            dec_from_rf;
    logic            use_rs1;
    logic            use_rs2;
    logic [4:0]      dec_op;
    logic [XLEN-1:0] dec_imm;
    logic            reg_bad;
    logic            dec_illegal;

    always_comb begin
        dec_ok      = 1'b0;
        dec_lui     = 1'b0;
        dec_from_rf = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        dec_op      = ALU_NONE;
        dec_imm     = '0;
        case (opcode)
            OPC_OP_IMM: begin
                dec_ok  = 1'b1;
                use_rs1 = 1'b1;
                dec_imm = XLEN'($signed(bus.instr[31:20]));
                case (funct3)
                    3'b000: dec_op = ALU_ADD;
                    3'b010: dec_op = ALU_SLT;
                    3'b011: dec_op = ALU_SLTU;
                    3'b100: dec_op = ALU_XOR;
                    3'b110: dec_op = ALU_OR;
                    3'b111: dec_op = ALU_AND;
                    3'b001: begin
                        dec_op  = ALU_SLL;
                        dec_imm = XLEN'(f_rs2);
                        dec_ok  = (funct7 == 7'b0000000);
                    end
                    default: begin
                        // funct3 101: funct7 selects logical vs arithmetic shift
                        dec_imm = XLEN'(f_rs2);
                        if (funct7 == 7'b0000000)      dec_op = ALU_SRL;
                        else if (funct7 == 7'b0100000) dec_op = ALU_SRA;
                        else                           dec_ok = 1'b0;
                    end
                endcase
            end
            OPC_OP: begin
                dec_ok      = 1'b1;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                dec_from_rf = 1'b1;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  dec_op = ALU_ADD;
                            3'b001:  dec_op = ALU_SLL;
                            3'b010:  dec_op = ALU_SLT;
                            3'b011:  dec_op = ALU_SLTU;
                            3'b100:  dec_op = ALU_XOR;
                            3'b101:  dec_op = ALU_SRL;
                            3'b110:  dec_op = ALU_OR;
                            default: dec_op = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000)      dec_op = ALU_SUB;
                        else if (funct3 == 3'b101) dec_op = ALU_SRA;
                        else                       dec_ok = 1'b0;
                    end
`ifdef DECODE_MULDIV_EN
                    7'b0000001: dec_op = {2'b10, funct3};
`else
                    7'b0000001: dec_ok = 1'b0;
`endif
                    default: dec_ok = 1'b0;
                endcase
            end
            OPC_LUI: begin
                dec_ok  = 1'b1;
                dec_lui = 1'b1;
                dec_op  = ALU_ADD;
                dec_imm = XLEN'($signed({bus.instr[31:12], 12'b0}));
            end
            default: dec_ok = 1'b0;
        endcase
    end

    // rd is written by every decodable form, so it is always range-checked.
    assign reg_bad = ({1'b0, f_rd} >= REG_LIMIT)
                   || (use_rs1 && ({1'b0, f_rs1} >= REG_LIMIT))
                   || (use_rs2 && ({1'b0, f_rs2} >= REG_LIMIT));
    assign dec_illegal = !dec_ok || reg_bad;

    logic             out_valid_q;
    logic [4:0]       rd_q;
    logic [4:0]       rs1_q;
    logic [4:0]       rs2_q;
    logic [XLEN-1:0]  imm_q;
    logic             from_rf_q;
    logic [4:0]       alu_op_q;
    logic             rf_we_q;
    logic             illegal_q;
    logic [CNT_W-1:0] ill_cnt_q;
    logic             in_ready_w;
    logic             accept;

    assign in_ready_w = !out_valid_q || bus.out_ready;
    assign accept     = bus.in_valid && in_ready_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            from_rf_q   <= 1'b0;
            alu_op_q    <= '0;
            rf_we_q     <= 1'b0;
            illegal_q   <= 1'b0;
            ill_cnt_q   <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            rd_q        <= f_rd;
            rs1_q       <= (dec_lui && !dec_illegal) ? 5'd0 : f_rs1;
            rs2_q       <= f_rs2;
            imm_q       <= dec_illegal ? '0 : dec_imm;
            from_rf_q   <= !dec_illegal && dec_from_rf;
            alu_op_q    <= dec_illegal ? ALU_NONE : dec_op;
            rf_we_q     <= !dec_illegal && (f_rd != 5'd0);
            illegal_q   <= dec_illegal;
            if (dec_illegal && (ill_cnt_q != '1))
                ill_cnt_q <= ill_cnt_q + CNT_W'(1);
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_w;
    assign bus.out_valid  = out_valid_q;
    assign bus.rd         = rd_q;
    assign bus.rs1        = rs1_q;
    assign bus.rs2        = rs2_q;
    assign bus.imm        = imm_q;
    assign bus.is_from_rf = from_rf_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.rf_we      = rf_we_q;
    assign bus.illegal    = illegal_q;
    assign bus.ill_cnt    = ill_cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 32-register/16-bit-counter instance and a
// 16-register/2-bit-counter instance share one stimulus stream.
module tb_decode_stage;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [4:0] A_NONE = 5'h00, A_ADD = 5'h01, A_XOR = 5'h02, A_OR = 5'h03;
  localparam logic [4:0] A_AND = 5'h04, A_SUB = 5'h05, A_SLTU = 5'h06, A_SLL = 5'h07;
  localparam logic [4:0] A_SRL = 5'h08, A_SRA = 5'h09, A_SLT = 5'h0A;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [31:0] instr;

  decode_stage_if #(.XLEN(32), .CNT_W(16)) bus_a ();
  decode_stage_if #(.XLEN(32), .CNT_W(2))  bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.flush     = flush;
  assign bus_a.out_ready = out_ready;
  assign bus_a.instr     = instr;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.flush     = flush;
  assign bus_b.out_ready = out_ready;
  assign bus_b.instr     = instr;

  decode_stage #(.XLEN(32), .NREGS(32), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  decode_stage #(.XLEN(32), .NREGS(16), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        from_rf;
    logic [4:0]  op;
    logic        we;
    logic        ill_a;
    logic        ill_b;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_cnt_a = 0;
  int          exp_cnt_b = 0;
  logic        mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  task automatic add(input logic [31:0] i, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm, input logic fr,
                     input logic [4:0] op, input logic we, input logic ia, input logic ib);
    vec_t v;
    v.instr = i; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.from_rf = fr; v.op = op; v.we = we; v.ill_a = ia; v.ill_b = ib;
    vecs.push_back(v);
  endtask

  // Issue-side scoreboard: every output handshake must match the next expected imm.
  always @(negedge clk) begin
    #4;
    if (mon_en && bus_a.out_valid && out_ready) begin
      if (exp_q.size() == 0) check("hs_unexpected", 64'd1, 64'd0);
      else check("hs_imm", 64'(bus_a.imm), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; instr = '0;

    add(32'hFFF00093, 1, 0, 31, 32'hFFFFFFFF, 0, A_ADD, 1, 0, 0);
    add(32'h402081B3, 3, 1, 2, 32'h0, 1, A_SUB, 1, 0, 0);
    add(32'h40109093, 1, 1, 1, 32'h0, 0, A_NONE, 0, 1, 1);
    add(enc_r(7'h00, 2, 1, 3'b000, 17), 17, 1, 2, 32'h0, 1, A_ADD, 1, 0, 1);
    add(enc_i(12'h7FF, 6, 3'b100, 5), 5, 6, 31, 32'h000007FF, 0, A_XOR, 1, 0, 0);
    add(enc_i(12'h800, 8, 3'b110, 7), 7, 8, 0, 32'hFFFFF800, 0, A_OR, 1, 0, 0);
    add(enc_i(12'h0F0, 10, 3'b111, 9), 9, 10, 16, 32'h000000F0, 0, A_AND, 1, 0, 0);
    add(enc_i(12'h001, 12, 3'b011, 11), 11, 12, 1, 32'h00000001, 0, A_SLTU, 1, 0, 0);
    add(enc_i(12'hFFB, 14, 3'b010, 13), 13, 14, 27, 32'hFFFFFFFB, 0, A_SLT, 1, 0, 0);
    add(enc_i(12'h41F, 1, 3'b101, 15), 15, 1, 31, 32'h0000001F, 0, A_SRA, 1, 0, 0);
    add(enc_i(12'h004, 3, 3'b101, 2), 2, 3, 4, 32'h00000004, 0, A_SRL, 1, 0, 0);
    add(enc_i(12'h003, 5, 3'b001, 4), 4, 5, 3, 32'h00000003, 0, A_SLL, 1, 0, 0);
    add(enc_i(12'h024, 7, 3'b101, 6), 6, 7, 4, 32'h0, 0, A_NONE, 0, 1, 1);
    add(enc_r(7'h00, 8, 7, 3'b001, 6), 6, 7, 8, 32'h0, 1, A_SLL, 1, 0, 0);
    add(enc_r(7'h00, 2, 18, 3'b010, 1), 1, 18, 2, 32'h0, 1, A_SLT, 1, 0, 1);
    add(enc_r(7'h00, 5, 4, 3'b011, 3), 3, 4, 5, 32'h0, 1, A_SLTU, 1, 0, 0);
    add(enc_r(7'h00, 8, 7, 3'b100, 6), 6, 7, 8, 32'h0, 1, A_XOR, 1, 0, 0);
    add(enc_r(7'h00, 11, 10, 3'b101, 9), 9, 10, 11, 32'h0, 1, A_SRL, 1, 0, 0);
    add(enc_r(7'h20, 14, 13, 3'b101, 12), 12, 13, 14, 32'h0, 1, A_SRA, 1, 0, 0);
    add(enc_r(7'h00, 3, 2, 3'b110, 1), 1, 2, 3, 32'h0, 1, A_OR, 1, 0, 0);
    add(enc_r(7'h00, 20, 2, 3'b111, 1), 1, 2, 20, 32'h0, 1, A_AND, 1, 0, 1);
    add(enc_r(7'h20, 5, 4, 3'b001, 3), 3, 4, 5, 32'h0, 0, A_NONE, 0, 1, 1);
    add(enc_r(7'h02, 5, 4, 3'b000, 3), 3, 4, 5, 32'h0, 0, A_NONE, 0, 1, 1);
    add(enc_r(7'h00, 2, 1, 3'b000, 0), 0, 1, 2, 32'h0, 1, A_ADD, 0, 0, 0);
    add(32'h123452B7, 5, 0, 3, 32'h12345000, 0, A_ADD, 1, 0, 0);
    add(32'hFFFFF037, 0, 0, 31, 32'hFFFFF000, 0, A_ADD, 0, 0, 0);
    add({20'hABCDE, 5'd20, 7'b0110111}, 20, 0, 28, 32'hABCDE000, 0, A_ADD, 1, 0, 1);
    add(32'h00000073, 0, 0, 0, 32'h0, 0, A_NONE, 0, 1, 1);
`ifdef DECODE_MULDIV_EN
    add(32'h023100B3, 1, 2, 3, 32'h0, 1, 5'h10, 1, 0, 0);
    add(enc_r(7'h01, 6, 5, 3'b101, 4), 4, 5, 6, 32'h0, 1, 5'h15, 1, 0, 0);
`else
    add(32'h023100B3, 1, 2, 3, 32'h0, 0, A_NONE, 0, 1, 1);
    add(enc_r(7'h01, 6, 5, 3'b101, 4), 4, 5, 6, 32'h0, 0, A_NONE, 0, 1, 1);
`endif
    add(32'hFFFFFFFF, 31, 31, 31, 32'h0, 0, A_NONE, 0, 1, 1);

    // Reset held two cycles.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
    check("rst_fields", 64'({bus_a.rd, bus_a.rs1, bus_a.rs2, bus_a.alu_op}), 64'd0);
    check("rst_imm", 64'(bus_a.imm), 64'd0);
    check("rst_flags", 64'({bus_a.is_from_rf, bus_a.rf_we, bus_a.illegal}), 64'd0);
    check("rst_ill_cnt_a", 64'(bus_a.ill_cnt), 64'd0);
    check("rst_ill_cnt_b", 64'(bus_b.ill_cnt), 64'd0);

    // Back-to-back table with out_ready held high.
    for (int i = 0; i <= vecs.size(); i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("vec_out_valid", 64'(bus_a.out_valid), 64'd1);
        check("vec_in_ready", 64'(bus_a.in_ready), 64'd1);
        check("vec_rd", 64'(bus_a.rd), 64'(vecs[i-1].rd));
        check("vec_rs1", 64'(bus_a.rs1), 64'(vecs[i-1].rs1));
        check("vec_rs2", 64'(bus_a.rs2), 64'(vecs[i-1].rs2));
        check("vec_imm", 64'(bus_a.imm), 64'(vecs[i-1].imm));
        check("vec_is_from_rf", 64'(bus_a.is_from_rf), 64'(vecs[i-1].from_rf));
        check("vec_alu_op", 64'(bus_a.alu_op), 64'(vecs[i-1].op));
        check("vec_rf_we", 64'(bus_a.rf_we), 64'(vecs[i-1].we));
        check("vec_illegal", 64'(bus_a.illegal), 64'(vecs[i-1].ill_a));
        check("vec_ill_cnt_a", 64'(bus_a.ill_cnt), 64'(exp_cnt_a));
        check("vec_b_illegal", 64'(bus_b.illegal), 64'(vecs[i-1].ill_b));
        check("vec_ill_cnt_b", 64'(bus_b.ill_cnt), 64'(exp_cnt_b));
      end
      if (i < vecs.size()) begin
        in_valid = 1'b1;
        instr = vecs[i].instr;
        if (vecs[i].ill_a) exp_cnt_a++;
        if (vecs[i].ill_b && exp_cnt_b < 3) exp_cnt_b++;
      end else begin
        in_valid = 1'b0;
      end
    end

    // Stall with a pending instruction, then release.
    @(negedge clk);
    check("drain_out_valid", 64'(bus_a.out_valid), 64'd0);
    mon_en = 1'b1;
    out_ready = 1'b0; in_valid = 1'b1; instr = enc_i(12'h005, 0, 3'b000, 1);
    exp_q.push_back(32'h5);
    @(negedge clk);
    check("stall_first_valid", 64'(bus_a.out_valid), 64'd1);
    instr = enc_i(12'h006, 0, 3'b000, 2);
    exp_q.push_back(32'h6);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(bus_a.in_ready), 64'd0);
      check("stall_hold_imm", 64'(bus_a.imm), 64'd5);
      check("stall_hold_rd", 64'(bus_a.rd), 64'd1);
      check("stall_out_valid", 64'(bus_a.out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 64'(bus_a.in_ready), 64'd1);
    @(negedge clk);
    check("release_imm", 64'(bus_a.imm), 64'd6);
    check("release_rd", 64'(bus_a.rd), 64'd2);
    check("release_out_valid", 64'(bus_a.out_valid), 64'd1);
    in_valid = 1'b0;
    @(negedge clk);
    check("release_drained", 64'(bus_a.out_valid), 64'd0);
    @(negedge clk);
    mon_en = 1'b0;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Flush has priority over a same-cycle accept.
    flush = 1'b1; in_valid = 1'b1; instr = 32'h00000073;
    @(negedge clk);
    check("flush_prio_valid", 64'(bus_a.out_valid), 64'd0);
    check("flush_prio_cnt", 64'(bus_a.ill_cnt), 64'(exp_cnt_a));
    flush = 1'b0; out_ready = 1'b0;
    exp_cnt_a++;
    @(negedge clk);
    check("flush_held_valid", 64'(bus_a.out_valid), 64'd1);
    check("flush_held_illegal", 64'(bus_a.illegal), 64'd1);
    check("flush_held_cnt", 64'(bus_a.ill_cnt), 64'(exp_cnt_a));
    in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("flush_drop_valid", 64'(bus_a.out_valid), 64'd0);
    check("flush_drop_cnt", 64'(bus_a.ill_cnt), 64'(exp_cnt_a));
    check("flush_cnt_b_sat", 64'(bus_b.ill_cnt), 64'd3);
    flush = 1'b0;

    // Reset while an instruction is stalled.
    in_valid = 1'b1; instr = enc_i(12'h00A, 0, 3'b000, 3);
    @(negedge clk);
    check("midstall_valid", 64'(bus_a.out_valid), 64'd1);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midstall_rst_valid", 64'(bus_a.out_valid), 64'd0);
    check("midstall_rst_ready", 64'(bus_a.in_ready), 64'd1);
    check("midstall_rst_imm", 64'(bus_a.imm), 64'd0);
    check("midstall_rst_cnt_a", 64'(bus_a.ill_cnt), 64'd0);
    check("midstall_rst_cnt_b", 64'(bus_b.ill_cnt), 64'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
